// File: rtl/dcsg_wrapper.sv
// SN76489-style DCSG: three square tone channels and one LFSR noise channel.
// Optional DCSG_FULL_DECODE_EN also requires address[15:8] == 8'h00.
module dcsg_wrapper #(
    parameter logic [7:0] IO_ADDRESS = 8'h3F
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        en_clk_psg_i,
    input  logic        n_ioreq,
    input  logic        n_wr,
    input  logic [15:0] address,
    input  logic [7:0]  wdata,
    output logic [13:0] sound_out
);

    logic [9:0]  period_q [3];
    logic [9:0]  cnt_q [3];
    logic [2:0]  tone_q;
    logic [3:0]  vol_q [4];
    logic [2:0]  nctrl_q;
    logic [15:0] lfsr_q;
    logic [3:0]  presc_q;
    logic [5:0]  ncnt_q;
    logic [1:0]  lch_q;
    logic        lvol_q;
    logic        wr_q;
    logic [13:0] sound_q;

    logic        wr_req;
    logic        wr_acc;
    logic        tick;
    logic [2:0]  tog;
    logic        t2_rise;
    logic        nshift;
    logic        fb;
    logic [1:0]  sel;
    logic        is_vol;
    logic        nwr;
    logic [3:0]  lvl;
    logic [13:0] sound_d;

`ifdef DCSG_FULL_DECODE_EN
    assign wr_req = !n_ioreq && !n_wr && address == {8'h00, IO_ADDRESS};
`else
    logic unused_addr_hi;
    assign unused_addr_hi = &address[15:8];
    assign wr_req = !n_ioreq && !n_wr && address[7:0] == IO_ADDRESS;
`endif

    // One register write per bus cycle: act only on the strobe's rising edge.
    assign wr_acc = wr_req && !wr_q;
    assign sel    = wdata[7] ? wdata[6:5] : lch_q;
    assign is_vol = wdata[7] ? wdata[4] : lvol_q;
    assign nwr    = wr_acc && !is_vol && sel == 2'd3;

    assign tick = en_clk_psg_i && presc_q == 4'd15;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tog[i] = cnt_q[i] <= 10'd1;
        end
    end

    assign t2_rise = tick && tog[2] && !tone_q[2];
    assign fb      = nctrl_q[2] ? (lfsr_q[0] ^ lfsr_q[3]) : lfsr_q[0];

    always_comb begin
        nshift = 1'b0;
        case (nctrl_q[1:0])
            2'd0: nshift = tick && ncnt_q[3:0] == 4'd15;
            2'd1: nshift = tick && ncnt_q[4:0] == 5'd31;
            2'd2: nshift = tick && ncnt_q == 6'd63;
            default: nshift = t2_rise;
        endcase
    end

    function automatic logic [11:0] amp(input logic [3:0] a);
        case (a)
            4'd0:    amp = 12'd4095;
            4'd1:    amp = 12'd3253;
            4'd2:    amp = 12'd2584;
            4'd3:    amp = 12'd2052;
            4'd4:    amp = 12'd1630;
            4'd5:    amp = 12'd1295;
            4'd6:    amp = 12'd1028;
            4'd7:    amp = 12'd817;
            4'd8:    amp = 12'd649;
            4'd9:    amp = 12'd515;
            4'd10:   amp = 12'd409;
            4'd11:   amp = 12'd325;
            4'd12:   amp = 12'd258;
            4'd13:   amp = 12'd205;
            4'd14:   amp = 12'd163;
            default: amp = 12'd0;
        endcase
    endfunction

    // Periods 0 and 1 hold the tone output high (DC).
    always_comb begin
        sound_d = 14'd0;
        for (int i = 0; i < 3; i++) begin
            lvl[i] = (period_q[i] <= 10'd1) || tone_q[i];
        end
        lvl[3] = lfsr_q[0];
        for (int i = 0; i < 4; i++) begin
            if (lvl[i]) begin
                sound_d = sound_d + {2'b00, amp(vol_q[i])};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < 3; i++) begin
                period_q[i] <= 10'd0;
                cnt_q[i]    <= 10'd0;
            end
            for (int i = 0; i < 4; i++) begin
                vol_q[i] <= 4'hF;
            end
            tone_q  <= 3'd0;
            nctrl_q <= 3'd0;
            lfsr_q  <= 16'h8000;
            presc_q <= 4'd0;
            ncnt_q  <= 6'd0;
            lch_q   <= 2'd0;
            lvol_q  <= 1'b0;
            wr_q    <= 1'b0;
            sound_q <= 14'd0;
        end else begin
            wr_q    <= wr_req;
            sound_q <= sound_d;
            if (en_clk_psg_i) begin
                presc_q <= presc_q + 4'd1;
            end
            if (tick) begin
                ncnt_q <= ncnt_q + 6'd1;
                for (int i = 0; i < 3; i++) begin
                    if (tog[i]) begin
                        cnt_q[i]  <= period_q[i];
                        tone_q[i] <= ~tone_q[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] - 10'd1;
                    end
                end
            end
            if (wr_acc && wdata[7]) begin
                lch_q  <= wdata[6:5];
                lvol_q <= wdata[4];
            end
            for (int i = 0; i < 3; i++) begin
                if (wr_acc && !is_vol && sel == 2'(i)) begin
                    if (wdata[7]) begin
                        period_q[i][3:0] <= wdata[3:0];
                    end else begin
                        period_q[i][9:4] <= wdata[5:0];
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (wr_acc && is_vol && sel == 2'(i)) begin
                    vol_q[i] <= wdata[3:0];
                end
            end
            if (nwr) begin
                nctrl_q <= wdata[2:0];
                lfsr_q  <= 16'h8000;
            end else if (nshift) begin
                lfsr_q <= {fb, lfsr_q[15:1]};
            end
        end
    end

    assign sound_out = sound_q;

endmodule

// File: tb/tb_dcsg_wrapper.sv
// Directed bench for dcsg_wrapper with a queue of expected results.
// Enable pulses run at clk/4, so one tone tick is 64 clks.
module tb_dcsg_wrapper;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        en_clk_psg_i = 1'b0;
    logic        n_ioreq = 1'b1;
    logic        n_wr = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic [13:0] sound_out;

    int passed = 0;
    int failed = 0;
    int total = 0;
    int exp_q[$];
    int div = 0;

    dcsg_wrapper #(.IO_ADDRESS(8'h3F)) dut (
        .clk(clk),
        .n_reset(n_reset),
        .en_clk_psg_i(en_clk_psg_i),
        .n_ioreq(n_ioreq),
        .n_wr(n_wr),
        .address(address),
        .wdata(wdata),
        .sound_out(sound_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div = (div + 1) % 4;
        en_clk_psg_i = (div == 0);
    end

    task automatic chk(input string tag, input int obs);
        int e;
        e = exp_q.pop_front();
        total++;
        assert (obs === e) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        wdata = d;
        n_ioreq = 1'b0;
        n_wr = 1'b0;
        repeat (12) @(negedge clk);
        n_ioreq = 1'b1;
        n_wr = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic watch(input int n, output int mx, output int mn,
                         output int odd);
        mx = 0;
        mn = 99999;
        odd = 0;
        repeat (n) begin
            @(negedge clk);
            if (int'(sound_out) > mx) mx = int'(sound_out);
            if (int'(sound_out) < mn) mn = int'(sound_out);
            if (sound_out != 14'd12285 && sound_out != 14'd16380) odd++;
        end
    endtask

    task automatic next_change(input int lim, output int n);
        logic [13:0] prev;
        prev = sound_out;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sound_out == prev && n < lim);
        if (sound_out == prev) n = -1;
    endtask

    initial begin
        int mx, mn, odd, n, v1, v2;

        repeat (5) @(negedge clk);
        exp_q.push_back(0);
        chk("reset_out", int'(sound_out));

        n_reset = 1'b1;
        watch(1000, mx, mn, odd);
        exp_q.push_back(0);
        chk("idle_silent", mx);

        bus_wr(16'h003F, 8'h8F);
        bus_wr(16'h003F, 8'h00);
        bus_wr(16'h003F, 8'h9F);
        watch(2000, mx, mn, odd);
        exp_q.push_back(0);
        chk("ch0_muted", mx);

        bus_wr(16'h003F, 8'h90);
        next_change(2000, n);
        v1 = int'(sound_out);
        next_change(2000, n);
        v2 = int'(sound_out);
        exp_q.push_back(960);
        chk("tone_half1", n);
        exp_q.push_back(4095);
        chk("tone_levels", v1 + v2);
        next_change(2000, n);
        exp_q.push_back(960);
        chk("tone_half2", n);

        bus_wr(16'h003F, 8'h90);
        bus_wr(16'h003F, 8'h0A);
        next_change(2000, n);
        v1 = int'(sound_out);
        next_change(2000, n);
        v2 = int'(sound_out);
        exp_q.push_back(409);
        chk("vol_a_levels", v1 + v2);
        exp_q.push_back(960);
        chk("vol_a_half", n);

        bus_wr(16'h003E, 8'h9F);
        next_change(2000, n);
        v1 = int'(sound_out);
        next_change(2000, n);
        v2 = int'(sound_out);
        exp_q.push_back(409);
        chk("wrong_port", v1 + v2);

        bus_wr(16'h013F, 8'h9F);
        watch(2000, mx, mn, odd);
`ifdef DCSG_FULL_DECODE_EN
        exp_q.push_back(409);
`else
        exp_q.push_back(0);
`endif
        chk("mirror_port", mx);

        bus_wr(16'h003F, 8'h81);
        bus_wr(16'h003F, 8'h00);
        bus_wr(16'h003F, 8'h90);
        bus_wr(16'h003F, 8'hA1);
        bus_wr(16'h003F, 8'h00);
        bus_wr(16'h003F, 8'hB0);
        bus_wr(16'h003F, 8'hC1);
        bus_wr(16'h003F, 8'h00);
        bus_wr(16'h003F, 8'hD0);
        bus_wr(16'h003F, 8'hF0);
        bus_wr(16'h003F, 8'hE4);
        exp_q.push_back(12285);
        chk("noise_reload", int'(sound_out));

        watch(17000, mx, mn, odd);
        exp_q.push_back(16380);
        chk("mix_max", mx);
        exp_q.push_back(12285);
        chk("mix_min", mn);
        exp_q.push_back(0);
        chk("mix_levels", odd);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dcsg_wrapper.md
Name: dcsg_wrapper

Overview:
- SN76489-compatible DCSG: 3 tone channels plus 1 noise channel.
- Attached to the Z80-style I/O bus of the cartridge as a write-only port.
- Produces a 14-bit unsigned mixed PCM level that feeds the downstream PWM/DAC stage.
- Runs on the 21.477 MHz system clock and is advanced by a single-cycle PSG enable pulse.

Parameters:
- IO_ADDRESS, 8'h3F, I/O port number decoded against address[7:0].

Ports:
- clk  in  1  system clock, 21.47727 MHz.
- n_reset  in  1  synchronous, active-low reset.
- en_clk_psg_i  in  1  one-clk-wide PSG clock enable; bench drives 1 of every 4 clk cycles.
- n_ioreq  in  1  active-low I/O request.
- n_wr  in  1  active-low write strobe.
- address  in  16  I/O address.
- wdata  in  8  write data.
- sound_out  out  16-bit? no: 14  unsigned mixed audio level.

Behaviour:
- Reset and clock: n_reset is synchronous, active-low; clock is clk. All state changes on posedge clk.
- Values held while n_reset=0:
  - tone periods 0; volumes 4'hF (silent); noise control 0.
  - LFSR 16'h8000; tone/noise outputs 0; prescaler 0.
  - sound_out 0; write-edge register 0.
- Write decode:
  - wr_req = !n_ioreq && !n_wr && address[7:0]==IO_ADDRESS.
  - wr_req is registered each clk. A write is accepted on the first clk where wr_req=1 and its registered copy=0.
  - Exactly one register write per bus cycle, however many clks the strobe is held (bus holds it ~12 clks).
  - Writes are processed regardless of en_clk_psg_i.
- Register protocol:
  - Byte with wdata[7]=1 is a latch byte: wdata[6:5] = channel (3 = noise), wdata[4] = 1 volume / 0 tone-or-noise, wdata[3:0] = data.
  - Latch byte stores channel and type in a latch register, then writes data to that register's low 4 bits. Noise control is 3 bits: wdata[2:0].
  - Byte with wdata[7]=0 is a data byte. If the latched register is a tone period: period[9:4] = wdata[5:0]. Otherwise (volume or noise): low 4 bits = wdata[3:0].
  - Any write to the noise control register reloads LFSR = 16'h8000.
- Prescaler: 4-bit counter incremented on each en_clk_psg_i. tick = en_clk_psg_i && prescaler==15, i.e. every 16 enables.
- Tone channels 0..2, on each tick:
  - 10-bit down counter. If counter<=1: reload with period and toggle the square output. Otherwise decrement.
  - Period 0 or 1: output forced 1 (DC).
  - Half period = period ticks.
- Noise channel:
  - Shift clock by ctrl[1:0]: 00 → every 16 ticks, 01 → every 32, 10 → every 64, 11 → on each 0→1 transition of tone channel 2 output.
  - On shift: LFSR = {fb, LFSR[15:1]}. fb = LFSR[0]^LFSR[3] when ctrl[2]=1 (white), else LFSR[0] (periodic).
  - Noise output = LFSR[0].
- Volume: 4-bit attenuation, 2 dB/step. Amplitude table index 0..15: 4095, 3253, 2584, 2052, 1630, 1295, 1028, 817, 649, 515, 409, 325, 258, 205, 163, 0.
- Mixer:
  - Each channel contributes its amplitude when its output bit=1, else 0.
  - sound_out = registered unsigned sum of the 4 contributions, updated every clk, 1 clk latency.
  - Maximum 16380, so the sum fits 14 bits without overflow.
- Reset mid-operation returns every register to the reset values above on the next clk edge.

Optional Feature:
- Macro DCSG_FULL_DECODE_EN.
- Defined: decode requires address[15:8]==8'h00 in addition to address[7:0]==IO_ADDRESS.
- Undefined (default): address[15:8] ignored, so the port is mirrored across all 256 upper values.

Test Plan:
- Reset, then 1000 clks idle with en_clk_psg_i at clk/4 → sound_out==0 throughout.
- Write 8'h8F, 8'h00, 8'h9F to port 16'h003F, 12-clk strobes → ch0 period=15, volume=F, sound_out stays 0.
- Write 8'h8F, 8'h00, 8'h90 → sound_out toggles between 0 and 4095 every 15 ticks = 240 enables = 960 clks.
- Hold one strobe for 12 clks with 8'h90, then write 8'h0A → exactly one write per strobe: ch0 volume becomes 4'hA (amplitude 409), tone period unchanged.
- Write to 16'h003E → no register change. Write to 16'h013F → accepted only when DCSG_FULL_DECODE_EN is undefined.
- Set tones 0..2 to period 1 and volume 0, noise volume 0, write noise 8'hE4 → LFSR reloads to 8000h, sound_out ≤16380, no wrap observed.
